// File: rtl/lsu_mem_sequencer.sv
// Per-warp LSU memory sequencer: serialises the active threads of one warp-wide
// load/store onto the single-ported data memory and gathers load results.
module lsu_mem_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_THREADS = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_is_store,
  input  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] in_wdata,
  input  logic [NUM_THREADS-1:0]                 in_mask,
  input  logic [1:0]                             in_warp,
  input  logic [3:0]                             in_rd,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic                                   mem_we,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [DATA_WIDTH-1:0]                  mem_wdata,
  input  logic                                   mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_is_store,
  output logic [1:0]                             out_warp,
  output logic [3:0]                             out_rd,
  output logic [NUM_THREADS-1:0]                 out_mask,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] out_rdata
);

  localparam int IDX_W = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                                 state_q, state_d;
  logic                                   is_store_q;
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [NUM_THREADS-1:0]                 mask_q;
  logic [1:0]                             warp_q;
  logic [3:0]                             rd_q;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]                       idx_q;

  logic             capture;
  logic             advance;
  logic             rd_we;
  logic [IDX_W:0]   first_set;
  logic [IDX_W:0]   next_set;

  // Returns {found, index} of the lowest set bit strictly above cur
  // (or at/above 0 when from_start); no wrap-around.
  function automatic logic [IDX_W:0] find_set(
    input logic [NUM_THREADS-1:0] m,
    input logic [IDX_W-1:0]       cur,
    input logic                   from_start
  );
    logic [IDX_W:0] r;
    r = '0;
    for (int unsigned i = NUM_THREADS; i > 0; i--) begin
      if (m[i-1] && (from_start || ((i - 1) > 32'(cur)))) begin
        r = {1'b1, IDX_W'(i - 1)};
      end
    end
    return r;
  endfunction

  assign first_set = find_set(in_mask, '0, 1'b1);
  assign next_set  = find_set(mask_q, idx_q, 1'b0);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    rd_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = (|in_mask) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          if (is_store_q) begin
            advance = 1'b1;
            state_d = next_set[IDX_W] ? ISSUE : DONE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          rd_we   = 1'b1;
          advance = 1'b1;
          state_d = next_set[IDX_W] ? ISSUE : DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      warp_q     <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        is_store_q <= in_is_store;
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
        mask_q     <= in_mask;
        warp_q     <= in_warp;
        rd_q       <= in_rd;
        rdata_q    <= '0;
        idx_q      <= first_set[IDX_W-1:0];
      end
      if (rd_we) begin
        rdata_q[idx_q] <= mem_rdata;
      end
      // On the last thread idx is left in place so the request fields stay put.
      if (advance && next_set[IDX_W]) begin
        idx_q <= next_set[IDX_W-1:0];
      end
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_we        = is_store_q;
  assign mem_addr      = addr_q[idx_q];
  assign mem_wdata     = wdata_q[idx_q];
  assign out_valid     = (state_q == DONE);
  assign out_is_store  = is_store_q;
  assign out_warp      = warp_q;
  assign out_rd        = rd_q;
  assign out_mask      = mask_q;
  assign out_rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer: request scoreboard, memory model,
// table-driven warp ops and hand-written stall/spurious/reset sequences.
module tb_lsu_mem_sequencer;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_is_store;
  logic [7:0][7:0]       in_addr;
  logic [7:0][15:0]      in_wdata;
  logic [7:0]            in_mask;
  logic [1:0]            in_warp;
  logic [3:0]            in_rd;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [7:0]            mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_rvalid = 1'b0;
  logic [15:0]           mem_rdata = '0;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_is_store;
  logic [1:0]            out_warp;
  logic [3:0]            out_rd;
  logic [7:0]            out_mask;
  logic [7:0][15:0]      out_rdata;

  lsu_mem_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_THREADS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_mask(in_mask),
    .in_warp(in_warp), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_store(out_is_store),
    .out_warp(out_warp), .out_rd(out_rd), .out_mask(out_mask), .out_rdata(out_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    logic             st;
    logic [1:0]       warp;
    logic [3:0]       rd;
    logic [7:0]       mask;
    logic [7:0][15:0] rdata;
    int               lat;
  } done_t;

  typedef struct {
    logic       st;
    logic [7:0] mask;
    logic [7:0] base;
    logic [7:0] step;
    logic [1:0] warp;
    logic [3:0] rd;
    int         lat;
  } vec_t;

  req_t  exp_req[$];
  done_t exp_done[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    hs_count = 0;
  logic  spur = 1'b0;

  logic             hs, hs_we;
  logic [7:0]       hs_addr;
  req_t             r_m;
  logic [7:0][7:0]  ta;
  logic [7:0][15:0] twd;
  vec_t             vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Memory model: handshake observed mid-cycle, read data returned the cycle after.
  always begin
    @(negedge clk);
    hs      = mem_req_valid && mem_req_ready && reset;
    hs_we   = mem_we;
    hs_addr = mem_addr;
    if (hs) begin
      hs_count++;
      if (exp_req.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %0h we %0b expected no request", mem_addr, mem_we);
      end else begin
        r_m = exp_req.pop_front();
        chk("mem_req", {7'b0, mem_we, mem_addr, mem_wdata}, {7'b0, r_m.we, r_m.addr, r_m.wdata});
      end
    end
    @(posedge clk);
    #1;
    mem_rvalid = (hs && !hs_we) || spur;
    mem_rdata  = spur ? 16'hDEAD : (16'hA000 + {8'h00, hs_addr});
  end

  task automatic issue(input logic st, input logic [7:0] m, input logic [7:0][7:0] a,
                       input logic [7:0][15:0] wd, input logic [1:0] w, input logic [3:0] r,
                       input int lat);
    done_t d;
    req_t  q;
    d.st = st; d.warp = w; d.rd = r; d.mask = m; d.lat = lat; d.rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        q.we = st; q.addr = a[i]; q.wdata = wd[i];
        exp_req.push_back(q);
        if (!st) d.rdata[i] = 16'hA000 + {8'h00, a[i]};
      end
    end
    exp_done.push_back(d);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_is_store = st; in_mask = m; in_addr = a;
    in_wdata = wd; in_warp = w; in_rd = r;
    step();
    acc_cyc = cyc;
    in_valid = 1'b0; in_is_store = ~st; in_mask = ~m; in_warp = ~w; in_rd = ~r;
    for (int i = 0; i < 8; i++) begin
      in_addr[i]  = 8'($urandom);
      in_wdata[i] = 16'($urandom);
    end
    chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_done(input int hold, input logic spur_done);
    done_t d;
    int    to;
    to = 0;
    while (!out_valid && to < 200) begin
      step();
      to++;
    end
    if (exp_done.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_queue: got completion expected none");
      return;
    end
    d = exp_done.pop_front();
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no out_valid after %0d cycles expected latency %0d", to, d.lat);
      return;
    end
    chk("latency", 32'(cyc - acc_cyc + 1), 32'(d.lat));
    chk("out_is_store", {31'b0, out_is_store}, {31'b0, d.st});
    chk("out_warp", {30'b0, out_warp}, {30'b0, d.warp});
    chk("out_rd", {28'b0, out_rd}, {28'b0, d.rd});
    chk("out_mask", {24'b0, out_mask}, {24'b0, d.mask});
    for (int i = 0; i < 8; i++) chk("out_rdata", {16'b0, out_rdata[i]}, {16'b0, d.rdata[i]});
    chk("reqs_drained", 32'(exp_req.size()), 32'd0);
    for (int h = 0; h < hold; h++) begin
      spur = spur_done;
      step();
      chk("held_out_valid", {31'b0, out_valid}, 32'd1);
      chk("held_in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 8; i++) chk("held_rdata", {16'b0, out_rdata[i]}, {16'b0, d.rdata[i]});
    end
    spur = 1'b0;
    out_ready = 1'b1;
    step();
    chk("in_ready_after_done", {31'b0, in_ready}, 32'd1);
    chk("out_valid_after_done", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int to;
    reset = 1'b0; in_valid = 1'b0; in_is_store = 1'b0; in_addr = '0; in_wdata = '0;
    in_mask = '0; in_warp = '0; in_rd = '0; mem_req_ready = 1'b1; out_ready = 1'b1;

    vecs[0] = '{1'b0, 8'hFF, 8'h10, 8'd1, 2'd0, 4'd1, 17};
    vecs[1] = '{1'b1, 8'hA5, 8'h40, 8'd2, 2'd1, 4'd3, 5};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'd1, 2'd2, 4'd5, 1};
    vecs[3] = '{1'b0, 8'h81, 8'h20, 8'd1, 2'd3, 4'd7, 5};
    vecs[4] = '{1'b1, 8'h01, 8'h30, 8'd1, 2'd0, 4'd4, 2};
    vecs[5] = '{1'b0, 8'h10, 8'h55, 8'd0, 2'd1, 4'd6, 3};
    vecs[6] = '{1'b0, 8'h3C, 8'h60, 8'd0, 2'd2, 4'd8, 9};
    vecs[7] = '{1'b1, 8'h80, 8'h70, 8'd1, 2'd3, 4'd15, 2};

    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_req_fields", {7'b0, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_tags", {17'b0, out_is_store, out_warp, out_rd, out_mask}, 32'd0);
    chk("rst_out_rdata", {31'b0, |out_rdata}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 8; i++) begin
        ta[i]  = 8'(vecs[v].base + vecs[v].step * 8'(i));
        twd[i] = {vecs[v].base ^ 8'h5A, 8'(i)};
      end
      issue(vecs[v].st, vecs[v].mask, ta, twd, vecs[v].warp, vecs[v].rd, vecs[v].lat);
      wait_done(0, 1'b0);
    end

    // Store with the first request stalled three cycles
    for (int i = 0; i < 8; i++) begin
      ta[i] = 8'h80 + 8'(i);
      twd[i] = 16'(i);
    end
    mem_req_ready = 1'b0;
    issue(1'b1, 8'hA5, ta, twd, 2'd1, 4'd2, 8);
    for (int s = 0; s < 4; s++) begin
      chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("stall_req_fields", {7'b0, mem_we, mem_addr, mem_wdata}, {7'b0, 1'b1, 8'h80, 16'h0000});
      if (s < 3) step();
    end
    mem_req_ready = 1'b1;
    wait_done(0, 1'b0);

    // Load with spurious rvalid while stalled in ISSUE and while held in DONE
    for (int i = 0; i < 8; i++) ta[i] = 8'h90 + 8'(3 * i);
    out_ready = 1'b0;
    mem_req_ready = 1'b0;
    issue(1'b0, 8'h06, ta, twd, 2'd3, 4'd9, 8);
    spur = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk("spur_req_addr", {23'b0, mem_req_valid, mem_addr}, {23'b0, 1'b1, 8'h93});
      chk("spur_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    spur = 1'b0;
    mem_req_ready = 1'b1;
    wait_done(5, 1'b1);

    // Reset while waiting for thread 3's read data
    for (int i = 0; i < 8; i++) ta[i] = 8'hC0 + 8'(i);
    start = hs_count;
    issue(1'b0, 8'hFF, ta, twd, 2'd2, 4'd11, 17);
    to = 0;
    while (hs_count < start + 4 && to < 100) begin
      step();
      to++;
    end
    chk("pre_rst_wait_rd", {23'b0, mem_req_valid, mem_addr}, {23'b0, 1'b0, 8'hC3});
    reset = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("arst_req_fields", {7'b0, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_tags", {17'b0, out_is_store, out_warp, out_rd, out_mask}, 32'd0);
    chk("arst_out_rdata", {31'b0, |out_rdata}, 32'd0);
    exp_req.delete();
    exp_done.delete();
    step();
    reset = 1'b1;
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_rdata", {31'b0, |out_rdata}, 32'd0);
    step();
    for (int i = 0; i < 8; i++) ta[i] = 8'h20 + 8'(i);
    issue(1'b0, 8'h0F, ta, twd, 2'd1, 4'd12, 9);
    wait_done(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_sequencer.md
# lsu_mem_sequencer

Per-warp memory request sequencer inside the LSU, directly downstream of the AGU. Accepts one warp-wide load or store (eight per-thread addresses plus mask and store data) and issues the active threads' accesses to the single-ported data memory one at a time, lowest thread first. For loads it gathers the returned words into a per-thread result vector and hands it, tagged with warp and destination register, to register-file writeback.

## Interface
- DATA_WIDTH, 16, memory word and register width
- ADDR_WIDTH, 8, data-memory address width (matches AGU output)
- NUM_THREADS, 8, threads per warp; fixed at 8 for this block
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  warp memory op offered
- in_ready  out  1  sequencer can accept (high only in IDLE)
- in_is_store  in  1  1 = store, 0 = load
- in_addr  in  ADDR_WIDTH x8  per-thread addresses from AGU
- in_wdata  in  DATA_WIDTH x8  per-thread store data
- in_mask  in  8  thread-active mask; bit i = thread i
- in_warp  in  2  warp number tag
- in_rd  in  4  destination register tag (loads)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_WIDTH  request address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- out_valid  out  1  warp op complete
- out_ready  in  1  writeback accepts completion
- out_is_store, out_warp, out_rd, out_mask  out  1/2/4/8  latched tags
- out_rdata  out  DATA_WIDTH x8  per-thread load results

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: in_ready=1. On in_valid: latch all in_* fields, clear out_rdata to 0, set idx = lowest set bit of in_mask. If in_mask==0, go to DONE; otherwise go to ISSUE.
- ISSUE: mem_req_valid=1, mem_addr=addr[idx], mem_we=is_store, mem_wdata=wdata[idx]. Hold these stable until mem_req_ready. On handshake:
  - store: idx = next set bit above idx; if none, go to DONE, else stay in ISSUE.
  - load: go to WAIT_RD.
- WAIT_RD: mem_req_valid=0. On mem_rvalid: out_rdata[idx] = mem_rdata; advance idx as above; go to ISSUE or DONE.
- DONE: out_valid=1, all out_* stable. On out_ready: go to IDLE.
- Inactive threads are never issued. Their out_rdata stays 0.
- Duplicate addresses are issued separately; no coalescing.
- mem_rvalid outside WAIT_RD is ignored. A store never waits for rvalid.
- in_valid outside IDLE is ignored, because in_ready=0.
- mem_we, mem_addr and mem_wdata are don't-care when mem_req_valid=0, but they drive the latched idx values.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, all out_* and idx = 0.
- Reset mid-operation aborts immediately. The in-flight request is dropped, and a later mem_rvalid is ignored.
- Accept at edge N puts the block in ISSUE from cycle N+1. The first mem_req_valid is seen in cycle N+1.
- Store, memory always ready: one request per cycle. out_valid is asserted k+1 cycles after accept for k active threads.
- Load, memory always ready, rvalid one cycle after the handshake: 2 cycles per active thread. An 8-thread load gives out_valid 17 cycles after accept.
- Mask 0: out_valid in the cycle after accept, with no memory traffic.
- Back-to-back: out_ready at edge M gives in_ready=1 in cycle M+1. There is no same-cycle completion-and-accept.
- idx is 3 bits. Next-set-bit search covers bits idx+1..7 only, with no wrap-around.

## Test plan
- Load, mask 0xFF, addr[i]=0x10+i, memory returns 0xA000+addr -> 8 reads at 0x10..0x17 in order, out_rdata[i]=0xA010+i, out_valid 17 cycles after accept.
- Store, mask 0xA5, wdata[i]=i, mem_req_ready low 3 cycles on the first request -> writes only for threads 0,2,5,7; request fields held stable during the stall; out_is_store=1; out_rdata all 0.
- Mask 0x00 load with in_warp=2, in_rd=5 -> no mem_req_valid; out_valid next cycle with out_warp=2, out_rd=5, out_mask=0.
- Spurious mem_rvalid during ISSUE and DONE, plus out_ready held low 5 cycles -> results unchanged; out_valid held; in_ready=0 throughout.
- Reset asserted in WAIT_RD of thread 3 -> all outputs return to reset values asynchronously. A subsequent mem_rvalid is ignored, and a new load completes correctly.
